mxrv_trap_ctrl: RTL and testbench

Trap and CSR-port controller for the mxrv core. It owns the single CSR-register port and shares it between the execute stage and an internal trap sequencer. The sequencer runs the multi-cycle ecall, machine-external-interrupt and mret sequences: it saves and restores mepc, mcause and mstatus. It also drives the hold and jump inputs of the PC register to redirect fetch.

---
 rtl/mxrv_trap_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_mxrv_trap_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mxrv_trap_ctrl.sv
// mxrv_trap_ctrl
// Trap and CSR-port controller for the mxrv core.
//
// This block owns the single CSR register-file port. The execute stage uses
// it while the block is idle. An internal sequencer takes the port for the
// ecall, machine-external-interrupt and mret sequences. The sequencer saves
// or restores mepc, mcause and mstatus, freezes the PC with hold_flag_o and
// redirects fetch with jump_flag_o / jump_addr_o.
//
// Ports
//   clk, rst                  : clock and synchronous active-high reset
//   ex_csr_req_i/we_i/addr_i/wdata_i : CSR access request from execute
//   ex_csr_gnt_o              : execute access performed this cycle
//   ex_csr_rdata_o            : read data (same as csr_rdata_i)
//   ecall_i, mret_i           : one-cycle retire pulses
//   irq_i                     : level-sensitive machine external interrupt
//   inst_addr_i               : PC of the instruction in execute
//   csr_addr_o/we_o/wdata_o   : CSR register-file port
//   csr_rdata_i               : combinational read of csr_addr_o
//   hold_flag_o, jump_flag_o, jump_addr_o : PC register control
module mxrv_trap_ctrl #(
  parameter logic [31:0] ECALL_CAUSE = 32'h0000_000B,
  parameter logic [31:0] IRQ_CAUSE   = 32'h8000_000B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_csr_req_i,
  input  logic        ex_csr_we_i,
  input  logic [11:0] ex_csr_addr_i,
  input  logic [31:0] ex_csr_wdata_i,
  output logic        ex_csr_gnt_o,
  output logic [31:0] ex_csr_rdata_o,
  input  logic        ecall_i,
  input  logic        mret_i,
  input  logic        irq_i,
  input  logic [31:0] inst_addr_i,
  output logic [11:0] csr_addr_o,
  output logic        csr_we_o,
  output logic [31:0] csr_wdata_o,
  input  logic [31:0] csr_rdata_i,
  output logic        hold_flag_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  typedef enum logic [3:0] {
    IDLE, T_RD_MST, T_WR_EPC, T_WR_CAUSE, T_WR_MST, T_RD_VEC,
    R_RD_EPC, R_RD_MST, R_WR_MST, JUMP
  } state_t;

  state_t      state_q, state_d;
  logic        mie_q;
  logic [31:0] cause_q, epc_q, tgt_q, mst_q;
  logic        hold_q, jump_q;

  logic ecall_acc, mret_acc, irq_acc;

  // Event acceptance in IDLE. An interrupt never steals a cycle in which
  // execute is using the port, so the ex access always completes first.
  always_comb begin
    ecall_acc = 1'b0;
    mret_acc  = 1'b0;
    irq_acc   = 1'b0;
    if (state_q == IDLE) begin
      ecall_acc = ecall_i;
      mret_acc  = !ecall_i && mret_i;
      irq_acc   = !ecall_i && !mret_i && irq_i && mie_q && !ex_csr_req_i;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ecall_acc || irq_acc) state_d = T_RD_MST;
        else if (mret_acc)        state_d = R_RD_EPC;
      end
      T_RD_MST:   state_d = T_WR_EPC;
      T_WR_EPC:   state_d = T_WR_CAUSE;
      T_WR_CAUSE: state_d = T_WR_MST;
      T_WR_MST:   state_d = T_RD_VEC;
      T_RD_VEC:   state_d = JUMP;
      R_RD_EPC:   state_d = R_RD_MST;
      R_RD_MST:   state_d = R_WR_MST;
      R_WR_MST:   state_d = JUMP;
      default:    state_d = IDLE;
    endcase
  end

  // CSR port multiplexer: execute in IDLE, sequencer everywhere else.
  always_comb begin
    csr_addr_o   = 12'h000;
    csr_we_o     = 1'b0;
    csr_wdata_o  = 32'h0;
    ex_csr_gnt_o = 1'b0;
    case (state_q)
      IDLE: begin
        csr_addr_o  = ex_csr_addr_i;
        csr_wdata_o = ex_csr_wdata_i;
        // An ecall/mret retiring this cycle owns the next cycles; the
        // coinciding ex access is dropped rather than half-performed.
        if (!(ecall_acc || mret_acc)) begin
          csr_we_o     = ex_csr_req_i && ex_csr_we_i;
          ex_csr_gnt_o = ex_csr_req_i;
        end
      end
      T_RD_MST: csr_addr_o = CSR_MSTATUS;
      T_WR_EPC: begin
        csr_addr_o  = CSR_MEPC;
        csr_we_o    = 1'b1;
        csr_wdata_o = epc_q;
      end
      T_WR_CAUSE: begin
        csr_addr_o  = CSR_MCAUSE;
        csr_we_o    = 1'b1;
        csr_wdata_o = cause_q;
      end
      T_WR_MST: begin
        // MPIE <- MIE, MIE <- 0
        csr_addr_o  = CSR_MSTATUS;
        csr_we_o    = 1'b1;
        csr_wdata_o = {mst_q[31:8], mst_q[3], mst_q[6:4], 1'b0, mst_q[2:0]};
      end
      T_RD_VEC: csr_addr_o = CSR_MTVEC;
      R_RD_EPC: csr_addr_o = CSR_MEPC;
      R_RD_MST: csr_addr_o = CSR_MSTATUS;
      R_WR_MST: begin
        // MIE <- MPIE, MPIE <- 1
        csr_addr_o  = CSR_MSTATUS;
        csr_we_o    = 1'b1;
        csr_wdata_o = {mst_q[31:8], 1'b1, mst_q[6:4], mst_q[7], mst_q[2:0]};
      end
      default: ;
    endcase
    // Reset aborts a sequence without letting the pending write commit.
    if (rst) begin
      csr_we_o     = 1'b0;
      ex_csr_gnt_o = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mie_q   <= 1'b0;
      cause_q <= 32'h0;
      epc_q   <= 32'h0;
      tgt_q   <= 32'h0;
      mst_q   <= 32'h0;
      hold_q  <= 1'b0;
      jump_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= (state_d != IDLE) && (state_d != JUMP);
      jump_q  <= (state_d == JUMP);
      if (ecall_acc) begin
        cause_q <= ECALL_CAUSE;
        epc_q   <= inst_addr_i;
      end else if (irq_acc) begin
        cause_q <= IRQ_CAUSE;
        epc_q   <= inst_addr_i;
      end
      case (state_q)
        T_RD_MST, R_RD_MST: mst_q <= csr_rdata_i;
        T_RD_VEC:           tgt_q <= csr_rdata_i & ~32'h3;
        R_RD_EPC:           tgt_q <= csr_rdata_i;
        default: ;
      endcase
      // Shadow of mstatus.MIE, fed by whichever master wrote mstatus.
      if (csr_we_o && (csr_addr_o == CSR_MSTATUS)) mie_q <= csr_wdata_o[3];
    end
  end

  assign hold_flag_o    = hold_q;
  assign jump_flag_o    = jump_q;
  assign jump_addr_o    = tgt_q;
  assign ex_csr_rdata_o = csr_rdata_i;

endmodule

// File: tb/tb_mxrv_trap_ctrl.sv
// Self-checking bench for mxrv_trap_ctrl. A CSR register file lives in the
// bench; expected CSR contents, targets and latencies come from a small
// architectural model of mstatus/mtvec/mepc/mcause.
module tb_mxrv_trap_ctrl;

  localparam logic [31:0] ECALL_CAUSE = 32'h0000_000B;
  localparam logic [31:0] IRQ_CAUSE   = 32'h8000_000B;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_csr_req_i = 1'b0, ex_csr_we_i = 1'b0;
  logic [11:0] ex_csr_addr_i = 12'h0;
  logic [31:0] ex_csr_wdata_i = 32'h0;
  logic        ex_csr_gnt_o;
  logic [31:0] ex_csr_rdata_o;
  logic        ecall_i = 1'b0, mret_i = 1'b0, irq_i = 1'b0;
  logic [31:0] inst_addr_i = 32'h0;
  logic [11:0] csr_addr_o;
  logic        csr_we_o;
  logic [31:0] csr_wdata_o;
  logic [31:0] csr_rdata_i;
  logic        hold_flag_o, jump_flag_o;
  logic [31:0] jump_addr_o;

  int checks = 0;
  int errors = 0;
  int iso_writes = 0;

  // Architectural model
  logic [31:0] m_mstatus = 32'h0, m_mtvec = 32'h0, m_mepc = 32'h0, m_mcause = 32'h0;

  always #5 clk = ~clk;

  mxrv_trap_ctrl dut (
    .clk(clk), .rst(rst),
    .ex_csr_req_i(ex_csr_req_i), .ex_csr_we_i(ex_csr_we_i),
    .ex_csr_addr_i(ex_csr_addr_i), .ex_csr_wdata_i(ex_csr_wdata_i),
    .ex_csr_gnt_o(ex_csr_gnt_o), .ex_csr_rdata_o(ex_csr_rdata_o),
    .ecall_i(ecall_i), .mret_i(mret_i), .irq_i(irq_i), .inst_addr_i(inst_addr_i),
    .csr_addr_o(csr_addr_o), .csr_we_o(csr_we_o), .csr_wdata_o(csr_wdata_o),
    .csr_rdata_i(csr_rdata_i),
    .hold_flag_o(hold_flag_o), .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o)
  );

  // CSR register file: combinational read, write on the rising edge.
  logic [31:0] csr_file [0:4095];
  always @(posedge clk) if (csr_we_o) csr_file[csr_addr_o] <= csr_wdata_o;
  assign csr_rdata_i = csr_file[csr_addr_o];

  // Counts writes to a CSR only execute ever targets (port isolation).
  always @(posedge clk) if (csr_we_o && csr_addr_o == 12'h340) iso_writes <= iso_writes + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ex_write(input logic [11:0] a, input logic [31:0] d);
    ex_csr_req_i = 1'b1; ex_csr_we_i = 1'b1; ex_csr_addr_i = a; ex_csr_wdata_i = d;
    #1;
    check("ex_wr_gnt", ex_csr_gnt_o, 1);
    check("ex_wr_we", csr_we_o, 1);
    tick();
    ex_csr_req_i = 1'b0; ex_csr_we_i = 1'b0;
    case (a)
      12'h300: m_mstatus = d;
      12'h305: m_mtvec   = d;
      12'h341: m_mepc    = d;
      12'h342: m_mcause  = d;
      default: ;
    endcase
    $display("ex write  csr %h = %h", a, d);
  endtask

  task automatic ex_read(input logic [11:0] a, input logic [31:0] exp, input string tag);
    ex_csr_req_i = 1'b1; ex_csr_we_i = 1'b0; ex_csr_addr_i = a;
    #1;
    check({tag, "_gnt"}, ex_csr_gnt_o, 1);
    check(tag, ex_csr_rdata_o, exp);
    check({tag, "_we"}, csr_we_o, 0);
    $display("ex read   csr %h -> %h (expect %h)", a, ex_csr_rdata_o, exp);
    tick();
    ex_csr_req_i = 1'b0;
  endtask

  // kind: 0 ecall, 1 irq, 2 mret. Called in an IDLE cycle where the event
  // is accepted. iso keeps an ex write request pending during the sequence.
  task automatic do_event(input int kind, input logic [31:0] pc, input bit iso);
    logic [31:0] exp_tgt, exp_mst, exp_cause;
    int nhold, w0;
    exp_cause = (kind == 0) ? ECALL_CAUSE : IRQ_CAUSE;
    if (kind == 2) begin
      exp_tgt = m_mepc;
      exp_mst = (m_mstatus & ~32'h8) | (m_mstatus[7] ? 32'h8 : 32'h0) | 32'h80;
      nhold = 3;
    end else begin
      exp_tgt = m_mtvec & ~32'h3;
      exp_mst = (m_mstatus & ~32'h88) | (m_mstatus[3] ? 32'h80 : 32'h0);
      nhold = 5;
    end
    w0 = iso_writes;
    inst_addr_i = pc;
    if (kind == 0) ecall_i = 1'b1;
    if (kind == 1) irq_i = 1'b1;
    if (kind == 2) mret_i = 1'b1;
    if (iso) begin
      ex_csr_req_i = 1'b1; ex_csr_we_i = 1'b1;
      ex_csr_addr_i = 12'h340; ex_csr_wdata_i = $urandom;
    end
    #1;
    check("acc_hold", hold_flag_o, 0);
    check("acc_gnt", ex_csr_gnt_o, 0);
    tick();
    ecall_i = 1'b0; mret_i = 1'b0; inst_addr_i = $urandom;
    for (int c = 1; c <= nhold; c++) begin
      check("seq_hold", hold_flag_o, 1);
      check("seq_jump", jump_flag_o, 0);
      check("seq_gnt", ex_csr_gnt_o, 0);
      tick();
    end
    ex_csr_req_i = 1'b0; ex_csr_we_i = 1'b0;
    #1;
    check("jmp_flag", jump_flag_o, 1);
    check("jmp_hold", hold_flag_o, 0);
    check("jmp_addr", jump_addr_o, exp_tgt);
    check("jmp_we", csr_we_o, 0);
    tick();
    check("end_hold", hold_flag_o, 0);
    check("end_jump", jump_flag_o, 0);
    if (iso) check("iso_writes", iso_writes, w0);
    irq_i = 1'b0;
    if (kind != 2) begin
      m_mepc = pc;
      m_mcause = exp_cause;
    end
    m_mstatus = exp_mst;
    $display("event %0d pc %h -> target %h mstatus %h", kind, pc, exp_tgt, exp_mst);
    ex_read(12'h341, m_mepc, "rb_mepc");
    ex_read(12'h342, m_mcause, "rb_mcause");
    ex_read(12'h300, m_mstatus, "rb_mstatus");
  endtask

  initial begin
    logic [31:0] pc;
    int kind;

    // Reset state
    tick();
    tick();
    check("rst_hold", hold_flag_o, 0);
    check("rst_jump", jump_flag_o, 0);
    check("rst_jaddr", jump_addr_o, 0);
    check("rst_we", csr_we_o, 0);
    check("rst_gnt", ex_csr_gnt_o, 0);
    rst = 1'b0;

    ex_write(12'h300, 32'h0);
    ex_write(12'h305, 32'h0);
    ex_write(12'h341, 32'h0);
    ex_write(12'h342, 32'h0);

    // ex pass-through
    ex_write(12'h300, 32'h8);
    ex_read(12'h300, 32'h8, "pass_rd");
    ex_write(12'h300, 32'h0);

    // ecall with port isolation
    ex_write(12'h305, 32'h100);
    ex_write(12'h300, 32'h8);
    do_event(0, 32'h40, 1'b1);
    ex_read(12'h341, 32'h40, "ecall_mepc");
    ex_read(12'h342, 32'hB, "ecall_mcause");
    ex_read(12'h300, 32'h80, "ecall_mstatus");

    // Interrupt masked while MIE = 0
    irq_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("irq_masked_hold", hold_flag_o, 0);
    end
    ex_write(12'h300, 32'h88);
    do_event(1, 32'h1234, 1'b0);
    ex_read(12'h342, 32'h8000000B, "irq_mcause");

    // Interrupt coinciding with an ex request
    ex_write(12'h300, 32'h8);
    irq_i = 1'b1;
    ex_csr_req_i = 1'b1; ex_csr_we_i = 1'b0; ex_csr_addr_i = 12'h305;
    #1;
    check("coin_gnt", ex_csr_gnt_o, 1);
    check("coin_rdata", ex_csr_rdata_o, m_mtvec);
    tick();
    ex_csr_req_i = 1'b0;
    check("coin_hold", hold_flag_o, 0);
    do_event(1, 32'h2000, 1'b0);

    // mret
    ex_write(12'h341, 32'h44);
    ex_write(12'h300, 32'h80);
    do_event(2, 32'h88, 1'b0);
    ex_read(12'h300, 32'h88, "mret_mstatus");

    // Randomized events
    for (int it = 0; it < 10; it++) begin
      kind = $urandom_range(0, 2);
      pc = $urandom;
      ex_write(12'h305, $urandom);
      ex_write(12'h341, $urandom);
      if (kind == 1) ex_write(12'h300, $urandom | 32'h8);
      else ex_write(12'h300, $urandom);
      do_event(kind, pc, (kind != 1) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    // Reset in the middle of a trap (state T_WR_CAUSE)
    ex_write(12'h300, 32'h0);
    pc = $urandom;
    inst_addr_i = pc;
    ecall_i = 1'b1;
    tick();
    ecall_i = 1'b0;
    tick();
    tick();
    check("mid_hold", hold_flag_o, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_we", csr_we_o, 0);
    tick();
    check("mid_rst_hold", hold_flag_o, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_hold", hold_flag_o, 0);
    check("post_rst_jump", jump_flag_o, 0);
    m_mepc = pc;
    ex_read(12'h342, m_mcause, "rst_mcause");
    ex_read(12'h341, m_mepc, "rst_mepc");
    ex_read(12'h300, m_mstatus, "rst_mstatus");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
